bht_sat_predictor: RTL and testbench
====================================

// Module: bht_sat_predictor
// PURPOSE
//   Parametrised branch history table: DEPTH = 2**ADDR_W saturating counters of CNT_W bits.
//   Fetch reads a taken/not-taken prediction combinationally; execute writes back resolved outcomes.
//   After reset or flush, a sweep FSM initialises every entry, emulating a single-write-port RAM.
//   Sits between the PC-select logic (read side) and the branch-resolution stage (update side).
// PARAMETERS
//   ADDR_W   5                  index bits taken from the PC; DEPTH = 2**ADDR_W entries
//   CNT_W    2                  counter width, minimum 1; prediction = counter MSB
//   INIT_VAL 2**(CNT_W-1)-1     value written by the sweep (weakly not-taken)
// PORTS
//   clk        in  1       clock, rising edge
//   rst_n      in  1       synchronous reset, active-low
//   flush      in  1       restart the initialisation sweep
//   rd_addr    in  ADDR_W  read index (fetch PC bits)
//   pred_taken out 1       prediction for rd_addr; 0 while busy
//   pred_ghr   out ADDR_W  history snapshot used for this read; tied to 0 when BHT_GSHARE_EN is undefined
//   upd_valid  in  1       resolved branch present this cycle
//   upd_addr   in  ADDR_W  index of the resolved branch
//   upd_taken  in  1       resolved direction
//   upd_ghr    in  ADDR_W  pred_ghr value returned with the branch; ignored when BHT_GSHARE_EN is undefined
//   busy       out 1       initialisation sweep in progress
// BEHAVIOUR
//   - Clock and reset: one clock (clk); rst_n is synchronous and active-low.
//   - Storage: DEPTH x CNT_W flops with one write path (sweep or update) per cycle. No async reset on the array.
//   - FSM states INIT and RUN; sweep pointer ptr is ADDR_W+1 bits.
//     - rst_n=0: state<=INIT, ptr<=0. Sweep GHR<=0 when BHT_GSHARE_EN is defined.
//     - INIT: each cycle write INIT_VAL to entry ptr and increment ptr. When ptr==DEPTH-1 is written, go to RUN next cycle.
//     - A sweep takes exactly DEPTH cycles. busy=1 from the reset-release cycle through the last sweep write.
//     - RUN: flush=1 returns to INIT with ptr<=0 and GHR<=0.
//     - flush=1 during INIT restarts the sweep at ptr=0.
//     - Reset mid-sweep restarts the sweep at 0.
//   - Output reset values: busy=1, pred_taken=0, pred_ghr=0.
//   - Read: combinational, zero latency. pred_taken = cnt[idx_r][CNT_W-1], gated to 0 while busy.
//   - Update: accepted only when state==RUN && upd_valid && !flush. Entries are written at the next rising edge.
//     - taken:     cnt <= (cnt == 2**CNT_W-1) ? cnt : cnt+1
//     - not taken: cnt <= (cnt == 0) ? cnt : cnt-1
//     - Updates presented during INIT, or in the cycle flush is asserted, are dropped silently.
//   - Same-cycle read and update to the same index: read returns the pre-update value (read-before-write, no bypass).
//     The new value is visible from the next cycle.
//   - Index wrap: all index arithmetic is modulo DEPTH (ADDR_W bits, no carry).
// CONFIGURATION
//   - BHT_GSHARE_EN defined:
//     - ADDR_W-bit global history register GHR.
//     - idx_r = rd_addr ^ GHR; pred_ghr = GHR.
//     - idx_w = upd_addr ^ upd_ghr.
//     - On each accepted update: GHR <= {GHR[ADDR_W-2:0], upd_taken}.
//     - GHR is cleared by reset or flush.
//   - BHT_GSHARE_EN undefined:
//     - idx_r = rd_addr; idx_w = upd_addr; pred_ghr = 0.
//     - upd_ghr is unused; no GHR flops are built.
// TESTING
//   1. Release rst_n, ADDR_W=5 -> busy=1 for exactly 32 cycles, pred_taken=0.
//      Afterwards every index reads 0 (INIT_VAL=01).
//   2. Three taken updates to idx 7, then read idx 7 -> counter 01->10->11->11 (saturates), pred_taken=1.
//      Three not-taken updates -> 10->01->00, then 00 holds; pred_taken=0.
//   3. Same cycle: rd_addr=3 and a taken update to 3 (cnt=01) -> pred_taken=0 that cycle, 1 the next cycle.
//   4. flush in RUN -> busy=1 for 32 cycles. Updates issued during the sweep are dropped; all entries read 01 afterwards.
//   5. Reset asserted at sweep ptr=10 -> sweep restarts at 0 and busy lasts 32 cycles after release.
//   6. BHT_GSHARE_EN: after taken, taken, not-taken updates, GHR=00110.
//      rd_addr=00110 reads entry 0 and pred_ghr=00110. An update with upd_addr=00110, upd_ghr=00110 writes entry 0.

Source files
------------

// File: rtl/bht_sat_predictor.sv
// Branch history table of saturating counters with an initialisation sweep FSM.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module bht_sat_predictor #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2,
  parameter logic [CNT_W-1:0] INIT_VAL = CNT_W'(2**(CNT_W-1) - 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_ghr,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  state_t            state, state_nxt;
  logic [ADDR_W:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]  cnt [DEPTH];
  logic [ADDR_W-1:0] idx_r, idx_w, wr_idx;
  logic [CNT_W-1:0]  wr_val;
  logic              wr_en, upd_acc;

  assign upd_acc = (state == RUN) && upd_valid && !flush;
  assign busy    = (state == INIT);

`ifdef BHT_GSHARE_EN
  logic [ADDR_W-1:0] ghr, ghr_nxt;

  assign idx_r    = rd_addr ^ ghr;
  assign idx_w    = upd_addr ^ upd_ghr;
  assign pred_ghr = ghr;

  always_comb begin
    ghr_nxt = ghr;
    if (flush)
      ghr_nxt = '0;
    else if (upd_acc)
      ghr_nxt = {ghr[ADDR_W-2:0], upd_taken};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ghr <= '0;
    else
      ghr <= ghr_nxt;
  end
`else
  logic unused_upd_ghr;

  assign idx_r          = rd_addr;
  assign idx_w          = upd_addr;
  assign pred_ghr       = '0;
  assign unused_upd_ghr = ^upd_ghr;
`endif

  // Read-before-write: the array is read combinationally before the edge that writes it.
  assign pred_taken = busy ? 1'b0 : cnt[idx_r][CNT_W-1];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wr_en     = 1'b0;
    wr_idx    = idx_w;
    wr_val    = upd_taken ? sat_inc(cnt[idx_w]) : sat_dec(cnt[idx_w]);
    case (state)
      INIT: begin
        if (flush) begin
          ptr_nxt = '0;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = ptr[ADDR_W-1:0];
          wr_val  = INIT_VAL;
          ptr_nxt = ptr + (ADDR_W+1)'(1);
          if (ptr == LAST_PTR)
            state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_nxt = INIT;
          ptr_nxt   = '0;
        end else if (upd_acc) begin
          wr_en = 1'b1;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Single write port shared by the sweep and the update path; no reset on the array.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n)
      cnt[wr_idx] <= wr_val;
  end

endmodule

// File: tb/tb_bht_sat_predictor.sv
// Directed bench for bht_sat_predictor (ADDR_W=5, CNT_W=2, INIT_VAL=01).
module tb_bht_sat_predictor;

  logic       clk = 1'b0;
  logic       rst_n, flush, pred_taken, upd_valid, upd_taken, busy;
  logic [4:0] rd_addr, pred_ghr, upd_addr, upd_ghr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_busy, seen, ones;

  always #5 clk = ~clk;

  bht_sat_predictor dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rd_addr(rd_addr),
    .pred_taken(pred_taken), .pred_ghr(pred_ghr), .upd_valid(upd_valid),
    .upd_addr(upd_addr), .upd_taken(upd_taken), .upd_ghr(upd_ghr), .busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int a, input bit t, input int g = 0);
    upd_valid = 1'b1;
    upd_addr  = 5'(a);
    upd_taken = t;
    upd_ghr   = 5'(g);
    step();
    upd_valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int a, input int exp);
    rd_addr = 5'(a);
    #1;
    check(tag, int'(pred_taken), exp);
  endtask

  // Counts rising edges while busy; also records whether pred_taken ever rose.
  task automatic measure_busy(output int n, output int p);
    n = 0;
    p = 0;
    while (busy && n < 100) begin
      #1;
      if (pred_taken) p = 1;
      n++;
      step();
    end
  endtask

  task automatic count_ones(output int c);
    c = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      if (pred_taken) c++;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; rd_addr = '0;
    upd_valid = 1'b0; upd_addr = '0; upd_taken = 1'b0; upd_ghr = '0;
    repeat (3) step();
    check("rst_busy", int'(busy), 1);
    check("rst_pred", int'(pred_taken), 0);
    check("rst_ghr", int'(pred_ghr), 0);

    // Sweep after reset release
    rst_n = 1'b1;
    rd_addr = 5'd7;
    measure_busy(n_busy, seen);
    check("sweep_len", n_busy, 32);
    check("sweep_pred_gated", seen, 0);
    count_ones(ones);
    check("sweep_all_01", ones, 0);

    // Saturation at both ends on entry 7
    upd(7, 1'b1); rd_chk("t1_10", 7, 1);
    upd(7, 1'b1); rd_chk("t2_11", 7, 1);
    upd(7, 1'b1); rd_chk("t3_11", 7, 1);
    upd(7, 1'b0); rd_chk("n1_10", 7, 1);
    upd(7, 1'b0); rd_chk("n2_01", 7, 0);
    upd(7, 1'b0); rd_chk("n3_00", 7, 0);
    upd(7, 1'b0); rd_chk("n4_00", 7, 0);
    upd(7, 1'b1); rd_chk("hold_01", 7, 0);
    upd(7, 1'b1); rd_chk("hold_10", 7, 1);
    rd_chk("neighbor_8", 8, 0);
    rd_chk("neighbor_6", 6, 0);

    // Same-cycle read and update to index 3
    rd_addr = 5'd3; upd_valid = 1'b1; upd_addr = 5'd3; upd_taken = 1'b1; upd_ghr = '0;
    #1;
    check("rbw_old", int'(pred_taken), 0);
    step();
    upd_valid = 1'b0;
    #1;
    check("rbw_new", int'(pred_taken), 1);
`ifndef BHT_GSHARE_EN
    check("ghr_tied0", int'(pred_ghr), 0);
`endif

    // Flush from RUN with updates during the sweep
    upd(9, 1'b1); upd(9, 1'b1);
    rd_chk("e9_11", 9, 1);
    flush = 1'b1; upd_valid = 1'b1; upd_addr = 5'd12; upd_taken = 1'b1;
    step();
    flush = 1'b0; upd_addr = 5'd0;
    rd_addr = 5'd9;
    measure_busy(n_busy, seen);
    upd_valid = 1'b0;
    check("flush_len", n_busy, 32);
    check("flush_pred_gated", seen, 0);
    count_ones(ones);
    check("flush_all_01", ones, 0);

    // Flush during the sweep restarts it
    flush = 1'b1; step(); flush = 1'b0;
    repeat (10) step();
    flush = 1'b1; step(); flush = 1'b0;
    measure_busy(n_busy, seen);
    check("flush_init_len", n_busy, 32);

    // Reset mid-sweep restarts at 0
    upd(4, 1'b1); rd_chk("e4_10", 4, 1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (10) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    measure_busy(n_busy, seen);
    check("rst_mid_len", n_busy, 32);
    count_ones(ones);
    check("rst_mid_all_01", ones, 0);

`ifdef BHT_GSHARE_EN
    // History 00110 after T,T,N; read 00110 hits entry 0
    upd(1, 1'b1); upd(2, 1'b1); upd(3, 1'b0);
    check("ghr_00110", int'(pred_ghr), 6);
    rd_chk("gs_e0_01", 6, 0);
    upd(6, 1'b1, 6);
    check("ghr_01101", int'(pred_ghr), 13);
    rd_chk("gs_e0_10", 13, 1);
    flush = 1'b1; step(); flush = 1'b0;
    check("ghr_flush", int'(pred_ghr), 0);
    measure_busy(n_busy, seen);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
